countdown_timer_bcd: RTL

COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

---
 rtl/countdown_timer_bcd.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer with BCD digit outputs and a one-second prescaler.
// Optional alarm latch enabled by defining COUNTDOWN_ALARM_EN.
module countdown_timer_bcd #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       load,
  input  logic       start_stop,
  input  logic [5:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [3:0] min_D1,
  output logic [3:0] min_D0,
  output logic [3:0] sec_D1,
  output logic [3:0] sec_D0,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state_dbg
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          all_zero;
  logic          last_sec;
  logic [7:0]    load_min_bcd;
  logic [7:0]    load_sec_bcd;
  logic [3:0]    dec_m1;
  logic [3:0]    dec_m0;
  logic [3:0]    dec_s1;
  logic [3:0]    dec_s0;

  // Clamp a binary 0..63 value to 59 and split it into tens/ones BCD digits.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [5:0] c;
    logic [3:0] t;
    logic [3:0] o;
    c = (v > 6'd59) ? 6'd59 : v;
    if (c >= 6'd50)      t = 4'd5;
    else if (c >= 6'd40) t = 4'd4;
    else if (c >= 6'd30) t = 4'd3;
    else if (c >= 6'd20) t = 4'd2;
    else if (c >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    o = 4'(c - 6'(t) * 6'd10);
    return {t, o};
  endfunction

  assign load_min_bcd = bin2bcd(preset_min);
  assign load_sec_bcd = bin2bcd(preset_sec);

  assign all_zero = (min_D1 == 4'd0) && (min_D0 == 4'd0) &&
                    (sec_D1 == 4'd0) && (sec_D0 == 4'd0);
  assign last_sec = (min_D1 == 4'd0) && (min_D0 == 4'd0) &&
                    (sec_D1 == 4'd0) && (sec_D0 == 4'd1);

  // One-second decrement with borrow rippling from seconds-ones upward.
  always_comb begin
    dec_m1 = min_D1;
    dec_m0 = min_D0;
    dec_s1 = sec_D1;
    dec_s0 = sec_D0;
    if (sec_D0 != 4'd0) begin
      dec_s0 = sec_D0 - 4'd1;
    end else begin
      dec_s0 = 4'd9;
      if (sec_D1 != 4'd0) begin
        dec_s1 = sec_D1 - 4'd1;
      end else begin
        dec_s1 = 4'd5;
        if (min_D0 != 4'd0) begin
          dec_m0 = min_D0 - 4'd1;
        end else begin
          dec_m0 = 4'd9;
          dec_m1 = (min_D1 != 4'd0) ? (min_D1 - 4'd1) : 4'd0;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic; load overrides everything, including a terminal tick
  always_comb begin
    next_state = state;
    if (load) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop && !all_zero) next_state = RUN;
        RUN: begin
          if (tick && last_sec)   next_state = DONE;
          else if (start_stop)    next_state = PAUSE;
        end
        PAUSE:   if (start_stop) next_state = RUN;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    running   = (state == RUN);
    tick      = (state == RUN) && (presc == PRESC_MAX);
    state_dbg = state;
  end

  // Prescaler: counts in RUN, frozen in PAUSE, cleared otherwise
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else begin
      case (state)
        RUN:     presc <= tick ? '0 : presc + 1'b1;
        PAUSE:   presc <= presc;
        default: presc <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      min_D1 <= 4'd0;
      min_D0 <= 4'd0;
      sec_D1 <= 4'd0;
      sec_D0 <= 4'd0;
    end else if (load) begin
      min_D1 <= load_min_bcd[7:4];
      min_D0 <= load_min_bcd[3:0];
      sec_D1 <= load_sec_bcd[7:4];
      sec_D0 <= load_sec_bcd[3:0];
    end else if (tick && !all_zero) begin
      min_D1 <= dec_m1;
      min_D0 <= dec_m0;
      sec_D1 <= dec_s1;
      sec_D0 <= dec_s0;
    end
  end

  // done is high in the first cycle that shows 00:00 in DONE
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= !load && tick && last_sec;
  end

`ifdef COUNTDOWN_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)                              alarm_q <= 1'b0;
    else if (load)                          alarm_q <= 1'b0;
    else if (tick && last_sec)              alarm_q <= 1'b1;
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule
